mem_port_arbiter: RTL and testbench

- Two-requester arbiter that shares one memory port between instruction fetch (requester 0) and load/store (requester 1) in the central core.
- Accepts one request at a time and sequences it through an issue/response handshake on the shared port.
- Drives the select line of the general-purpose 2:1 muxes that steer the address, write-data and response paths.
- Round-robin between requesters on ties; one transaction outstanding at most.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (req0)
// and load/store (req1). One transaction outstanding, round-robin on ties.
// Optional response timeout: define MEM_PORT_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req0_we,
  input  logic              req1_we,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // A zero limit would expire before the first wait cycle could be counted.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_grant_q, last_grant_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                grant1_c;
  logic                idle_c;

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    idle_c     = (state_q == IDLE);
    grant1_c   = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = idle_c && req0_valid && !grant1_c;
    req1_ready = idle_c && grant1_c;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = busy_q;
`ifdef MEM_PORT_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          sel_d       = grant1_c;
          mem_addr_d  = grant1_c ? req1_addr  : req0_addr;
          mem_wdata_d = grant1_c ? req1_wdata : req0_wdata;
          mem_we_d    = grant1_c ? req1_we    : req0_we;
          mem_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = WAIT;
`ifdef MEM_PORT_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rsp0_valid_d = !sel_q;
          rsp1_valid_d = sel_q;
          rsp_rdata_d  = mem_rdata;
          rsp_err_d    = 1'b0;
          last_grant_d = sel_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
`ifdef MEM_PORT_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp0_valid_d = !sel_q;
          rsp1_valid_d = sel_q;
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b1;
          last_grant_d = sel_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
`ifdef MEM_PORT_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign sel        = sel_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response pulse.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_we, req1_we;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rdata;
  logic          sel, busy;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_we(req0_we), .req1_we(req1_we),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [DW-1:0] rdata, input logic err,
                      input logic chk_data);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      exp_t e;
      chk("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b expected none at %0t",
                 rsp0_valid, rsp1_valid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_port", 64'(rsp1_valid), 64'(e.port));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  initial begin
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    req0_we = 1'b0; req1_we = 1'b0; mem_rdata = '0;
    do_reset();
    #1;
    chk("reset_mem_valid", 64'(mem_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sel", 64'(sel), 64'd0);
    chk("reset_rsp", 64'({rsp0_valid, rsp1_valid, rsp_err}), 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_mem_fields", mem_addr | mem_wdata | 64'(mem_we), 64'd0);

    // Basic read from req0, minimum latency.
    req0_valid = 1'b1; req0_addr = 64'h100; req0_we = 1'b0;
    #1;
    chk("t1_req0_ready", 64'(req0_ready), 64'd1);
    chk("t1_req1_ready", 64'(req1_ready), 64'd0);
    push(1'b0, 64'hDEAD, 1'b0, 1'b1);
    tick();
    req0_valid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("t1_mem_valid", 64'(mem_valid), 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h100);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    chk("t1_sel_issue", 64'(sel), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD;
    #1;
    chk("t1_mem_valid_drop", 64'(mem_valid), 64'd0);
    chk("t1_sel_wait", 64'(sel), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("t1_rsp0_t3", 64'(rsp0_valid), 64'd1);
    chk("t1_rdata_t3", rsp_rdata, 64'hDEAD);
    chk("t1_busy_t3", 64'(busy), 64'd0);
    tick();
    chk("t1_rsp0_pulse_end", 64'(rsp0_valid), 64'd0);

    // Fairness: both valid from reset, memory always ready and responding.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 64'h200; req1_addr = 64'h300;
    mem_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'hA5;
    for (int k = 0; k <= 12; k++) begin
      logic g;
      g = ((k / 3) % 2) == 1;
      if (k == 10) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (k % 3 == 0 && k < 12) begin
        chk("rr_ready0", 64'(req0_ready), 64'(!g));
        chk("rr_ready1", 64'(req1_ready), 64'(g));
        push(g, 64'hA5, 1'b0, 1'b1);
      end
      if (k % 3 == 1) begin
        chk("rr_sel", 64'(sel), 64'(g));
        chk("rr_mem_addr", mem_addr, g ? 64'h300 : 64'h200);
      end
      tick();
    end
    mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    tick();

    // req1 write with a stalled memory port.
    req1_valid = 1'b1; req1_addr = 64'h8; req1_wdata = 64'h55; req1_we = 1'b1;
    #1;
    chk("wr_req1_ready", 64'(req1_ready), 64'd1);
    push(1'b1, 64'h0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("wr_hold_addr", mem_addr, 64'h8);
      chk("wr_hold_wdata", mem_wdata, 64'h55);
      chk("wr_hold_we", 64'(mem_we), 64'd1);
      chk("wr_hold_valid", 64'(mem_valid), 64'd1);
      chk("wr_no_ready", 64'({req0_ready, req1_ready}), 64'd0);
      tick();
    end
    req1_valid = 1'b0; req1_we = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("wr_wait_busy", 64'(busy), 64'd1);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("wr_rsp1", 64'(rsp1_valid), 64'd1);
    tick();

    // Stray memory responses in IDLE and ISSUE are ignored.
    mem_rsp_valid = 1'b1; mem_rdata = 64'h99;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("stray_idle", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    req0_valid = 1'b1; req0_addr = 64'h40; req0_we = 1'b0;
    #1;
    chk("stray_req0_ready", 64'(req0_ready), 64'd1);
    push(1'b0, 64'h77, 1'b0, 1'b1);
    tick();
    req0_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    chk("stray_issue", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("stray_rsp0", 64'(rsp0_valid), 64'd1);
    tick();

    // Reset while WAITing: transaction dropped, tie goes to req0 again.
    req0_valid = 1'b1; req0_addr = 64'h60;
    tick();
    req0_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; reset = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h11;
    tick();
    reset = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    chk("rst_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 64'h70;
    #1;
    chk("rst_tie_ready0", 64'(req0_ready), 64'd1);
    chk("rst_tie_ready1", 64'(req1_ready), 64'd0);
    push(1'b0, 64'h22, 1'b0, 1'b1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h22;
    tick();
    mem_rsp_valid = 1'b0;
    tick();

`ifdef MEM_PORT_TIMEOUT_EN
    // Timeout after 4 silent WAIT cycles (last grant was req0, so req1 here).
    req1_valid = 1'b1; req1_addr = 64'h80;
    push(1'b1, 64'h0, 1'b1, 1'b1);
    tick();
    req1_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("to_wait_busy", 64'(busy), 64'd1);
      chk("to_no_rsp_yet", 64'(rsp1_valid), 64'd0);
      tick();
    end
    #1;
    chk("to_rsp1", 64'(rsp1_valid), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    tick();
    // Response on the expiry cycle wins over the timeout.
    req0_valid = 1'b1; req0_addr = 64'h90;
    push(1'b0, 64'hBEEF, 1'b0, 1'b1);
    tick();
    req0_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_rsp_valid = 1'b1; mem_rdata = 64'hBEEF;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("to_race_rsp0", 64'(rsp0_valid), 64'd1);
    chk("to_race_err", 64'(rsp_err), 64'd0);
    tick();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
